// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with hold limit.
// Grants are registered, held until release, and separated by a gap cycle.
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic       gnt_valid_o,
  output logic [2:0] gnt_idx_o,
  output logic [7:0] gnt_onehot_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       oh_q, oh_d;
  logic             tmo_q, tmo_d;

  logic             win_found;
  logic [2:0]       win_idx;
  logic [2:0]       cand;

  // Find first requester after the last owner, wrapping mod 8.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          ptr_d   = win_idx;
          idx_d   = win_idx;
          cnt_d   = CNT_W'(1);
          vld_d   = 1'b1;
          oh_d    = 8'b1 << win_idx;
        end
      end
      S_GRANT: begin
        if (done_i || !req_i[idx_q] || cnt_q == HOLD_LIM) begin
          state_d = S_GAP;
          vld_d   = 1'b0;
          oh_d    = 8'h00;
          cnt_d   = '0;
          tmo_d   = !done_i && req_i[idx_q];
        end else if (cnt_q != HOLD_LIM) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd7;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      idx_q   <= 3'd0;
      oh_q    <= 8'h00;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt_valid_o  = vld_q;
  assign gnt_idx_o    = idx_q;
  assign gnt_onehot_o = oh_q;
  assign timeout_o    = tmo_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed and random stimulus for rr_arbiter8
// against a behavioural round-robin model.
module tb_rr_arbiter8;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       timeout;

  int total;
  int bad;

  // Model state: owner, cycles held, last owner, gap pending.
  bit m_valid;
  int m_idx;
  int m_last;
  int m_held;
  bit m_gap;
  bit m_tmo;

  rr_arbiter8 #(
    .HOLD_MAX(HOLD),
    .CNT_W(8)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_i(req),
    .done_i(done),
    .gnt_valid_o(gnt_valid),
    .gnt_idx_o(gnt_idx),
    .gnt_onehot_o(gnt_onehot),
    .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input logic [7:0] r,
                            input logic d,
                            input logic rn);
    int w;
    m_tmo = 1'b0;
    if (!rn) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_last  = 7;
      m_held  = 0;
      m_gap   = 1'b0;
    end else if (m_valid) begin
      if (d || !r[m_idx]) begin
        m_valid = 1'b0;
        m_gap   = 1'b1;
      end else if (m_held >= HOLD) begin
        m_valid = 1'b0;
        m_gap   = 1'b1;
        m_tmo   = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      w = -1;
      for (int k = 1; k <= 8; k++) begin
        if (w < 0 && r[(m_last + k) % 8]) w = (m_last + k) % 8;
      end
      if (w >= 0) begin
        m_valid = 1'b1;
        m_idx   = w;
        m_last  = w;
        m_held  = 1;
      end
    end
  endtask

  task automatic step(input logic [7:0] r,
                      input logic d,
                      input logic rn);
    logic [7:0] oh;
    req   = r;
    done  = d;
    rst_n = rn;
    @(posedge clk);
    model_edge(r, d, rn);
    #1;
    oh = m_valid ? (8'h01 << m_idx) : 8'h00;
    chk("valid", 32'(gnt_valid), 32'(m_valid));
    chk("idx", 32'(gnt_idx), 32'(m_idx));
    chk("onehot", 32'(gnt_onehot), 32'(oh));
    chk("timeout", 32'(timeout), 32'(m_tmo));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_last  = 7;
    m_held  = 0;
    m_gap   = 1'b0;
    m_tmo   = 1'b0;
    req     = 8'h00;
    done    = 1'b0;
    rst_n   = 1'b0;

    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("rst_vld", 32'(gnt_valid), 32'd0);
    chk("rst_oh", 32'(gnt_onehot), 32'd0);
    step(8'h00, 1'b0, 1'b1);

    // Single request, done in third grant cycle.
    step(8'h04, 1'b0, 1'b1);
    chk("single_idx", 32'(gnt_idx), 32'd2);
    chk("single_oh", 32'(gnt_onehot), 32'h04);
    step(8'h04, 1'b0, 1'b1);
    step(8'h04, 1'b0, 1'b1);
    step(8'h04, 1'b1, 1'b1);
    chk("single_rel", 32'(gnt_valid), 32'd0);
    step(8'h04, 1'b0, 1'b1);
    chk("single_gap", 32'(gnt_valid), 32'd0);
    step(8'h04, 1'b0, 1'b1);
    chk("single_regrant", 32'(gnt_valid), 32'd1);
    step(8'h04, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // Rotation with all requesting, done on first grant cycle.
    for (int n = 0; n < 30; n++) begin
      step(8'hFF, gnt_valid, 1'b1);
    end
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // Pointer wrap: grant 6, then 6 and 0 request.
    step(8'h40, 1'b0, 1'b1);
    chk("wrap6", 32'(gnt_idx), 32'd6);
    step(8'h40, 1'b1, 1'b1);
    step(8'h41, 1'b0, 1'b1);
    step(8'h41, 1'b0, 1'b1);
    chk("wrap0", 32'(gnt_idx), 32'd0);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // Timeout with persistent request.
    for (int n = 0; n < 14; n++) begin
      step(8'h08, 1'b0, 1'b1);
    end
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // Withdrawal mid-grant.
    step(8'h20, 1'b0, 1'b1);
    step(8'h20, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    chk("withdraw_tmo", 32'(timeout), 32'd0);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // done coincident with hold limit.
    step(8'h02, 1'b0, 1'b1);
    for (int n = 1; n < HOLD; n++) step(8'h02, 1'b0, 1'b1);
    step(8'h02, 1'b1, 1'b1);
    chk("done_lim_tmo", 32'(timeout), 32'd0);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // Reset mid-grant.
    step(8'h10, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b0);
    chk("midrst_vld", 32'(gnt_valid), 32'd0);
    chk("midrst_oh", 32'(gnt_onehot), 32'd0);
    chk("midrst_idx", 32'(gnt_idx), 32'd0);
    step(8'h81, 1'b0, 1'b1);
    chk("post_rst_idx", 32'(gnt_idx), 32'd0);
    step(8'h81, 1'b1, 1'b1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] r;
      logic d;
      logic rn;
      r  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      d  = ($urandom_range(0, 4) == 0);
      rn = ($urandom_range(0, 99) != 0);
      step(r, d, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
